// File: rtl/me_stage_vlat.sv
// Memory stage between EX and WB for a variable-latency req/addr_ok/data_ok bus; extracts load data, raises ALE, forwards to ID/EX.
// Latency: non-memory/excepting ops leave the cycle after capture; memory ops take one REQ cycle per addr_ok wait, then WAIT until data_ok.
// Backpressure: wb_allow_in low parks a finished result in a hold register (DONE); me_allow_in drops until WB accepts.
// Optional macro ME_FWD_BYPASS_EN: forward load data combinationally in the data_ok cycle instead of waiting for DONE.
module me_stage_vlat #(
    parameter int                 XLEN     = 32,
    parameter int                 DEST_W   = 5,
    parameter int                 EXCP_W   = 6,
    parameter logic [EXCP_W-1:0]  ALE_CODE = 6'h09,
    parameter int                 DISC_W   = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ex_valid,
    output logic                me_allow_in,
    input  logic [31:0]         ex_pc,
    input  logic [XLEN-1:0]     ex_result,
    input  logic [XLEN-1:0]     ex_wdata,
    input  logic                ex_mem_re,
    input  logic                ex_mem_we,
    input  logic [1:0]          ex_mem_size,
    input  logic                ex_mem_sext,
    input  logic                ex_gr_we,
    input  logic [DEST_W-1:0]   ex_dest,
    input  logic                ex_excp_en,
    input  logic [EXCP_W-1:0]   ex_excp_num,
    input  logic                flush,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [XLEN/8-1:0]   data_wstrb,
    output logic [31:0]         data_addr,
    output logic [XLEN-1:0]     data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [XLEN-1:0]     data_rdata,
    input  logic                wb_allow_in,
    output logic                wb_valid,
    output logic [31:0]         wb_pc,
    output logic                wb_gr_we,
    output logic [DEST_W-1:0]   wb_dest,
    output logic [XLEN-1:0]     wb_result,
    output logic                wb_excp_en,
    output logic [EXCP_W-1:0]   wb_excp_num,
    output logic                me_excp,
    output logic [DEST_W-1:0]   me_dest,
    output logic                me_fwd_valid,
    output logic [XLEN-1:0]     me_fwd_data
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);
    localparam logic [DISC_W-1:0] DISC_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic                me_valid;
    logic [31:0]         pc_q;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     wdata_q;
    logic                mem_re_q;
    logic                mem_we_q;
    logic [1:0]          size_q;
    logic                sext_q;
    logic                gr_we_q;
    logic [DEST_W-1:0]   dest_q;
    logic                excp_en_q;
    logic [EXCP_W-1:0]   excp_num_q;
    logic [XLEN-1:0]     hold_q;
    logic [DISC_W-1:0]   disc_cnt;
    logic                orphan;

    // Dword is only a legal size on a 64-bit datapath; otherwise it always faults.
    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        logic m;
        case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = a[0];
            2'd2:    m = |a[1:0];
            default: m = (XLEN != 64) | (|a);
        endcase
        return m;
    endfunction

    function automatic logic [NB-1:0] size_mask(input logic [1:0] sz);
        logic [NB-1:0] m;
        m = '0;
        case (sz)
            2'd0:    m[0]   = 1'b1;
            2'd1:    m[1:0] = 2'b11;
            2'd2:    m[3:0] = 4'hf;
            default: m      = '1;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] replicate(input logic [1:0] sz, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (sz)
            2'd0:    r = {NB{d[7:0]}};
            2'd1:    r = {(NB/2){d[15:0]}};
            2'd2:    r = {(NB/4){d[31:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Shift the addressed lane down to bit 0, then zero/sign-extend by access size.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] rd, input logic [OFF_W-1:0] off,
                                                input logic [1:0] sz, input logic sx);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] keep;
        logic            sb;
        lane = rd >> {off, 3'b000};
        keep = '0;
        case (sz)
            2'd0:    begin keep[7:0]  = '1; sb = lane[7];  end
            2'd1:    begin keep[15:0] = '1; sb = lane[15]; end
            2'd2:    begin keep[31:0] = '1; sb = lane[31]; end
            default: begin keep       = '1; sb = 1'b0;     end
        endcase
        return (lane & keep) | ({XLEN{sx & sb}} & ~keep);
    endfunction

    logic               is_mem;
    logic               ale;
    logic               excp_any;
    logic               resp;
    logic               drain;
    logic               disc_inc;
    logic [XLEN-1:0]    ext_data;
    logic               ready_go;
    logic               cap;
    logic               ex_is_mem;
    logic               ex_exc;
    logic               issue_ok;
    logic               launch_new;
    logic               launch_old;
    logic               launch;
    logic               nx_we;
    logic [1:0]         nx_size;
    logic [31:0]        nx_addr;
    logic [XLEN-1:0]    nx_wdata;
    logic               load_fwd;
    logic               fwd_ok;
    logic [XLEN-1:0]    fwd_src;

    assign is_mem    = mem_re_q | mem_we_q;
    assign ale       = is_mem & misaligned(size_q, result_q[2:0]);
    assign excp_any  = excp_en_q | ale;
    // A response belongs to the current op only once all orphaned responses have drained.
    assign resp      = data_data_ok & (disc_cnt == '0);
    assign drain     = data_data_ok & (disc_cnt != '0);
    assign ext_data  = extract(data_rdata, result_q[OFF_W-1:0], size_q, sext_q);

    // Stage completion per FSM state.
    always_comb begin
        ready_go = 1'b0;
        case (state)
            S_IDLE:  ready_go = me_valid & (!is_mem | excp_any);
            S_REQ:   ready_go = 1'b0;
            S_WAIT:  ready_go = resp;
            S_DONE:  ready_go = 1'b1;
            default: ready_go = 1'b0;
        endcase
    end

    assign me_allow_in = !me_valid | (ready_go & wb_allow_in);
    assign cap         = ex_valid & me_allow_in & !flush;
    assign ex_is_mem   = ex_mem_re | ex_mem_we;
    assign ex_exc      = ex_excp_en | (ex_is_mem & misaligned(ex_mem_size, ex_result[2:0]));
    assign issue_ok    = (disc_cnt != DISC_MAX) & !orphan;
    assign launch_new  = cap & ex_is_mem & !ex_exc & issue_ok;
    // A memory op sitting valid in IDLE was captured while issue was blocked.
    assign launch_old  = !flush & me_valid & (state == S_IDLE) & is_mem & !excp_any & issue_ok;
    assign launch      = ((state == S_IDLE) & (launch_new | launch_old)) |
                         ((((state == S_WAIT) & resp) | (state == S_DONE)) & wb_allow_in & launch_new);

    assign nx_we       = launch_new ? ex_mem_we   : mem_we_q;
    assign nx_size     = launch_new ? ex_mem_size : size_q;
    assign nx_addr     = launch_new ? ex_result[31:0] : result_q[31:0];
    assign nx_wdata    = launch_new ? ex_wdata    : wdata_q;

    // Orphans count on the flush edge if the request already went out, else when the held request is accepted.
    assign disc_inc    = (flush & (((state == S_REQ) & data_addr_ok) | ((state == S_WAIT) & !resp))) |
                         (orphan & data_addr_ok);

    // Result mux: hold register in DONE, pass-through load data in WAIT, ALU result otherwise.
    always_comb begin
        wb_result = result_q;
        case (state)
            S_DONE:  wb_result = hold_q;
            S_WAIT:  wb_result = mem_re_q ? ext_data : result_q;
            default: wb_result = result_q;
        endcase
    end

    assign wb_valid    = me_valid & ready_go;
    assign wb_pc       = pc_q;
    assign wb_dest     = dest_q;
    assign wb_excp_en  = me_valid & excp_any;
    assign wb_excp_num = !wb_excp_en ? '0 : (excp_en_q ? excp_num_q : ALE_CODE);
    assign wb_gr_we    = gr_we_q & !wb_excp_en;
    assign me_excp     = me_valid & excp_any;
    assign me_dest     = (me_valid & gr_we_q) ? dest_q : '0;

    assign load_fwd    = mem_re_q & !excp_any;
`ifdef ME_FWD_BYPASS_EN
    assign fwd_ok      = (state == S_DONE) | ((state == S_WAIT) & resp);
    assign fwd_src     = wb_result;
`else
    // No path from data_rdata to the forwarding network; loads forward from the hold register.
    assign fwd_ok      = (state == S_DONE);
    assign fwd_src     = (state == S_DONE) ? hold_q : result_q;
`endif
    assign me_fwd_valid = me_valid & (!load_fwd | fwd_ok);
    assign me_fwd_data  = (me_valid & gr_we_q) ? fwd_src : '0;

    // Pipeline capture, orphan counter, bus request registers and FSM.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            me_valid   <= 1'b0;
            pc_q       <= '0;
            result_q   <= '0;
            wdata_q    <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            size_q     <= '0;
            sext_q     <= 1'b0;
            gr_we_q    <= 1'b0;
            dest_q     <= '0;
            excp_en_q  <= 1'b0;
            excp_num_q <= '0;
            hold_q     <= '0;
            disc_cnt   <= '0;
            orphan     <= 1'b0;
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
        end else begin
            if (disc_inc && !drain) begin
                if (disc_cnt != DISC_MAX) disc_cnt <= disc_cnt + 1'b1;
            end else if (drain && !disc_inc) begin
                disc_cnt <= disc_cnt - 1'b1;
            end

            if (flush)            me_valid <= 1'b0;
            else if (me_allow_in) me_valid <= ex_valid;

            if (cap) begin
                pc_q       <= ex_pc;
                result_q   <= ex_result;
                wdata_q    <= ex_wdata;
                mem_re_q   <= ex_mem_re;
                mem_we_q   <= ex_mem_we;
                size_q     <= ex_mem_size;
                sext_q     <= ex_mem_sext;
                gr_we_q    <= ex_gr_we;
                dest_q     <= ex_dest;
                excp_en_q  <= ex_excp_en;
                excp_num_q <= ex_excp_num;
            end

            if (orphan && data_addr_ok) begin
                orphan   <= 1'b0;
                data_req <= 1'b0;
            end

            if (flush) begin
                state <= S_IDLE;
                if (state == S_REQ) begin
                    if (data_addr_ok) data_req <= 1'b0;
                    else              orphan   <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: if (launch) state <= S_REQ;
                    S_REQ: begin
                        if (data_addr_ok) begin
                            state    <= S_WAIT;
                            data_req <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (resp) begin
                            if (wb_allow_in) begin
                                state <= launch ? S_REQ : S_IDLE;
                            end else begin
                                state  <= S_DONE;
                                hold_q <= mem_re_q ? ext_data : result_q;
                            end
                        end
                    end
                    S_DONE: if (wb_allow_in) state <= launch ? S_REQ : S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end

            if (launch) begin
                data_req   <= 1'b1;
                data_wr    <= nx_we;
                data_size  <= nx_size;
                data_addr  <= nx_addr;
                data_wstrb <= size_mask(nx_size) << nx_addr[OFF_W-1:0];
                data_wdata <= replicate(nx_size, nx_wdata);
            end
        end
    end

endmodule
